// File: rtl/shared_resource_arbiter_3_pkg.sv
// Shared definitions for the three-requester round-robin arbiter.
package shared_resource_arbiter_3_pkg;

  localparam int unsigned HOLD_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

  // Index of the set bit in a one-hot pick; all-zero maps to 0.
  function automatic logic [1:0] onehot_idx(input logic [2:0] oh);
    if (oh[1])      return 2'd1;
    else if (oh[2]) return 2'd2;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/rr_pick_3.sv
// Combinational round-robin pick: searches Last+1, Last+2, Last (mod 3).
module rr_pick_3 (
  input  logic [2:0] i_req,
  input  logic [1:0] i_last,
  output logic [2:0] o_pick,
  output logic       o_valid
);

  logic [1:0] w_idx;

  always_comb begin
    o_pick  = '0;
    o_valid = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= 3; k++) begin
      w_idx = 2'((32'(i_last) + k) % 3);
      if (!o_valid && i_req[w_idx]) begin
        o_pick[w_idx] = 1'b1;
        o_valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_resource_arbiter_3.sv
// Round-robin arbiter granting one of three masters a shared resource,
// with per-input polarity, hold timeout and a one-cycle turnaround.
module shared_resource_arbiter_3
  import shared_resource_arbiter_3_pkg::*;
#(
  parameter logic [2:0]  BubblesMask   = 3'b000,
  parameter int unsigned MaxHoldCycles = 15
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Request_1,
  input  logic Request_2,
  input  logic Request_3,
  input  logic Done,
  output logic Grant_1,
  output logic Grant_2,
  output logic Grant_3,
  output logic Busy,
  output logic Timeout,
  output logic Idle
);

  localparam bit LIMIT_EN = (MaxHoldCycles != 0);
  localparam logic [HOLD_CNT_WIDTH-1:0] HOLD_LAST =
    HOLD_CNT_WIDTH'((MaxHoldCycles == 0) ? 0 : MaxHoldCycles - 1);

  arb_state_e                r_state, w_state_nxt;
  logic [2:0]                r_grant, w_grant_nxt;
  logic [1:0]                r_last, w_last_nxt;
  logic [HOLD_CNT_WIDTH-1:0] r_hold, w_hold_nxt;
  logic                      r_busy, w_busy_nxt;
  logic                      r_timeout, w_timeout_nxt;

  logic [2:0] w_req;
  logic [2:0] w_pick;
  logic       w_valid;
  logic       w_owner_req;
  logic       w_limit;

  assign w_req       = {Request_3, Request_2, Request_1} ^ BubblesMask;
  assign w_owner_req = |(w_req & r_grant);
  assign w_limit     = LIMIT_EN && (r_hold == HOLD_LAST);

  rr_pick_3 u_pick (
    .i_req   (w_req),
    .i_last  (r_last),
    .o_pick  (w_pick),
    .o_valid (w_valid)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_grant_nxt   = r_grant;
    w_last_nxt    = r_last;
    w_hold_nxt    = r_hold;
    w_busy_nxt    = r_busy;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_grant_nxt = w_pick;
          w_last_nxt  = onehot_idx(w_pick);
          w_hold_nxt  = '0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = GRANTED;
        end
      end
      GRANTED: begin
        // Done / request drop outrank the hold limit, so Timeout only
        // fires when the limit is the sole release cause.
        if (Done || !w_owner_req || w_limit) begin
          w_grant_nxt   = '0;
          w_busy_nxt    = 1'b0;
          w_timeout_nxt = !(Done || !w_owner_req);
          w_state_nxt   = RECOVER;
        end else if (r_hold != '1) begin
          w_hold_nxt = r_hold + 1'b1;
        end
      end
      RECOVER: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_grant   <= '0;
      r_last    <= 2'd2;
      r_hold    <= '0;
      r_busy    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_grant   <= w_grant_nxt;
      r_last    <= w_last_nxt;
      r_hold    <= w_hold_nxt;
      r_busy    <= w_busy_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign Grant_1 = r_grant[0];
  assign Grant_2 = r_grant[1];
  assign Grant_3 = r_grant[2];
  assign Busy    = r_busy;
  assign Timeout = r_timeout;
  assign Idle    = (r_state == IDLE) && !(|w_req);

endmodule

// File: tb/tb_shared_resource_arbiter_3.sv
// Randomized and directed checks of shared_resource_arbiter_3 against a
// cycle-level behavioural model of the arbitration rules.
module tb_shared_resource_arbiter_3;

  localparam logic [2:0] BM  = 3'b010;
  localparam int         MHC = 4;

  logic clk = 1'b0;
  logic rst;
  logic req1, req2, req3, done;
  logic g1, g2, g3, busy, tmo, idle;

  int n_checks = 0;
  int n_fail   = 0;

  int m_owner;
  int m_last;
  int m_hold;
  bit m_rec;
  bit m_to;

  always #5 clk = ~clk;

  shared_resource_arbiter_3 #(
    .BubblesMask   (BM),
    .MaxHoldCycles (MHC)
  ) dut (
    .Clock     (clk),
    .Reset     (rst),
    .Request_1 (req1),
    .Request_2 (req2),
    .Request_3 (req3),
    .Done      (done),
    .Grant_1   (g1),
    .Grant_2   (g2),
    .Grant_3   (g3),
    .Busy      (busy),
    .Timeout   (tmo),
    .Idle      (idle)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] eff();
    return {req3, req2, req1} ^ BM;
  endfunction

  // Drive requests in effective (active-high) terms.
  task automatic set_eff(input logic [2:0] e);
    logic [2:0] raw;
    raw  = e ^ BM;
    req1 = raw[0];
    req2 = raw[1];
    req3 = raw[2];
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 2;
    m_hold  = 0;
    m_rec   = 1'b0;
    m_to    = 1'b0;
  endtask

  task automatic model_step();
    logic [2:0] e;
    e    = eff();
    m_to = 1'b0;
    if (m_owner >= 0) begin
      if (done || !e[m_owner]) begin
        m_owner = -1;
        m_rec   = 1'b1;
      end else if (MHC != 0 && m_hold == MHC - 1) begin
        m_owner = -1;
        m_rec   = 1'b1;
        m_to    = 1'b1;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end else if (m_rec) begin
      m_rec = 1'b0;
    end else begin
      for (int k = 1; k <= 3; k++) begin
        int idx;
        idx = (m_last + k) % 3;
        if (m_owner < 0 && e[idx]) begin
          m_owner = idx;
          m_last  = idx;
          m_hold  = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0] exp_g;
    exp_g = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
    check_eq("grant",   {g3, g2, g1}, exp_g);
    check_eq("busy",    busy, m_owner >= 0);
    check_eq("timeout", tmo, m_to);
    check_eq("idle",    idle, (m_owner < 0) && !m_rec && (eff() == 3'b000));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic sync_reset_pulse();
    @(negedge clk);
    rst = 1'b1;
    #1;
    model_reset();
    check_eq("rst_grant", {g3, g2, g1}, 3'b000);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    int g_high;
    int t_pulses;
    int guard;

    rst  = 1'b1;
    done = 1'b0;
    set_eff(3'b000);
    model_reset();
    #2;
    check_eq("reset_grant",   {g3, g2, g1}, 3'b000);
    check_eq("reset_busy",    busy, 1'b0);
    check_eq("reset_timeout", tmo, 1'b0);
    check_eq("reset_idle",    idle, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Single request, then Done release and turnaround.
    set_eff(3'b001);
    cycle();
    check_eq("first_grant", {g3, g2, g1}, 3'b001);
    cycle();
    done = 1'b1;
    cycle();
    check_eq("done_release", {g3, g2, g1}, 3'b000);
    done = 1'b0;
    set_eff(3'b000);
    for (int i = 0; i < 3; i++) cycle();
    check_eq("idle_after", idle, 1'b1);

    // All requests held, Done pulsed each grant: order 1,2,3,1,2,3.
    sync_reset_pulse();
    set_eff(3'b111);
    cnt   = 0;
    guard = 0;
    while (cnt < 6 && guard < 60) begin
      done = (m_owner >= 0);
      cycle();
      if ({g3, g2, g1} != 3'b000 && !done) begin
        check_eq("rr_order", {g3, g2, g1}, 3'b001 << (cnt % 3));
        cnt++;
      end
      guard++;
    end
    check_eq("rr_order_count", cnt, 6);
    done = 1'b0;
    set_eff(3'b000);
    for (int i = 0; i < 4; i++) cycle();

    // Hold limit: Grant_2 high exactly MHC cycles, one Timeout pulse.
    set_eff(3'b010);
    g_high   = 0;
    t_pulses = 0;
    for (int i = 0; i < 6; i++) begin
      cycle();
      if (g2) g_high++;
      if (tmo) t_pulses++;
    end
    check_eq("hold_len", g_high, MHC);
    check_eq("timeout_pulses", t_pulses, 1);
    set_eff(3'b000);
    for (int i = 0; i < 4; i++) cycle();

    // Done coinciding with the hold limit: no Timeout.
    set_eff(3'b010);
    guard = 0;
    while (!(m_owner >= 0 && m_hold == MHC - 1) && guard < 20) begin
      cycle();
      guard++;
    end
    check_eq("coincide_reached", guard < 20, 1'b1);
    done = 1'b1;
    cycle();
    check_eq("coincide_grant", {g3, g2, g1}, 3'b000);
    check_eq("coincide_timeout", tmo, 1'b0);
    done = 1'b0;
    set_eff(3'b000);
    for (int i = 0; i < 3; i++) cycle();

    // Owner drops its request mid-grant.
    set_eff(3'b001);
    cycle();
    cycle();
    set_eff(3'b000);
    cycle();
    check_eq("drop_release", {g3, g2, g1}, 3'b000);
    for (int i = 0; i < 3; i++) cycle();

    // Asynchronous reset mid-grant.
    set_eff(3'b100);
    guard = 0;
    while (m_owner < 0 && guard < 10) begin
      cycle();
      guard++;
    end
    check_eq("async_pre_grant", {g3, g2, g1}, 3'b100);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_grant", {g3, g2, g1}, 3'b000);
    check_eq("async_busy", busy, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    set_eff(3'b101);
    cycle();
    check_eq("post_reset_pick", {g3, g2, g1}, 3'b001);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++) begin
      set_eff(3'($urandom_range(0, 7)));
      done = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
